hdmi_pix_fetch: RTL

- Downstream read stage between the LPDDR2 frame-buffer port (4-port RAM interface) and the HDMI-TX pixel bus.
- Issues sequential single-word reads over an Avalon-style port and buffers returned words in an internal FIFO.
- Pops one 24-bit RGB pixel per active-video cycle requested by the HDMI timing generator.
- Runs entirely on the 25.2 MHz pixel clock.

---
 rtl/img_cap_pkg.sv | 11 +
 rtl/hdmi_pix_fetch_fifo.sv | 50 +++++
 rtl/hdmi_pix_fetch.sv | 112 +++++++++++
 3 files changed

// File: rtl/img_cap_pkg.sv
// img_cap_pkg: shared FSM state, resolution defaults and bus widths for the HDMI pixel fetch path
package img_cap_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DONE} fetch_state_e;
    localparam int H_ACTIVE_640 = 640;
    localparam int V_ACTIVE_480 = 480;
    localparam int PIX_W = 24;
    localparam int AVL_DATA_W = 32;
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/hdmi_pix_fetch_fifo.sv
// pix_fifo: single-clock pixel FIFO
// Ports: clk, reset (async active-low); push/din write; pop reads head, which is
// always visible on dout; flush empties the FIFO; level is occupancy, empty flags zero.
module pix_fifo
    import img_cap_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LW = lvl_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic wr_en, rd_en;
    always_comb begin
        rd_en = pop && !flush && (lvl_q != '0);
        // a full FIFO still accepts a write when the head leaves in the same cycle
        wr_en = push && !flush && (lvl_q != LW'(DEPTH) || rd_en);
        wr_d  = flush ? '0 : wr_q + AW'(wr_en);
        rd_d  = flush ? '0 : rd_q + AW'(rd_en);
        lvl_d = flush ? '0 : lvl_q + LW'(wr_en) - LW'(rd_en);
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end
    assign dout  = mem_q[rd_q];
    assign level = lvl_q;
    assign empty = (lvl_q == '0);
endmodule

// File: rtl/hdmi_pix_fetch.sv
// hdmi_pix_fetch: frame-buffer read stage feeding the HDMI-TX pixel bus
// Ports: clk pixel clock; reset async active-low; ram_rdy memory calibrated;
// frame_start restarts the frame; pix_de pops one pixel per cycle;
// avl_ready/avl_read_req/avl_addr form the read request; rd_data_valid/rd_data the return;
// pix_data registered pixel; underflow sticky empty-pop flag; fifo_level FIFO occupancy.
module hdmi_pix_fetch
    import img_cap_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_640,
    parameter int V_ACTIVE = V_ACTIVE_480,
    parameter int ADDR_W = 29,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int FIFO_DEPTH = 16,
    localparam int LW = lvl_w(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ram_rdy,
    input  logic                  frame_start,
    input  logic                  pix_de,
    input  logic                  avl_ready,
    output logic                  avl_read_req,
    output logic [ADDR_W-1:0]     avl_addr,
    input  logic                  rd_data_valid,
    input  logic [AVL_DATA_W-1:0] rd_data,
    output logic [PIX_W-1:0]      pix_data,
    output logic                  underflow,
    output logic [LW-1:0]         fifo_level
);
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CW = $clog2(TOTAL + 1);
    fetch_state_e state_q, state_d;
    logic req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] out_q, out_d, disc_q, disc_d;
    // stale: the pending request was issued for a frame that has since restarted
    logic stale_q, stale_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic und_q, und_d;
    logic acc, restart, push, pop, empty;
    logic [LW-1:0] level, lvl_nx;
    logic [PIX_W-1:0] head;
    logic unused_hi;
    assign unused_hi = ^rd_data[AVL_DATA_W-1:PIX_W];
    pix_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (restart),
        .din   (rd_data[PIX_W-1:0]),
        .dout  (head),
        .level (level),
        .empty (empty)
    );
    always_comb begin
        acc     = req_q && avl_ready;
        restart = frame_start && (ram_rdy || state_q != IDLE);
        push    = rd_data_valid && disc_q == '0 && !restart;
        pop     = pix_de && !empty && !restart;
        lvl_nx  = restart ? '0 : level + LW'(push) - LW'(pop);
        out_d   = out_q + LW'(acc) - LW'(rd_data_valid);
        // every return still owed at a restart is dropped, including one arriving now
        disc_d  = restart ? out_q + LW'(req_q) - LW'(rd_data_valid)
                : (rd_data_valid && disc_q != '0) ? disc_q - 1'b1 : disc_q;
        cnt_d   = restart ? '0 : (acc && !stale_q) ? cnt_q + 1'b1 : cnt_q;
        stale_d = restart ? (req_q && !avl_ready) : (acc ? 1'b0 : stale_q);
        // a held request keeps its address; the next new one starts at BASE_ADDR after a restart
        addr_d  = acc ? ((restart || stale_q) ? BASE_ADDR : addr_q + 1'b1)
                : (restart && !req_q) ? BASE_ADDR : addr_q;
        state_d = !ram_rdy ? IDLE
                : restart ? FETCH
                : (state_q == FETCH && cnt_d == CW'(TOTAL)) ? DONE : state_q;
        // credits are judged on next-cycle occupancy so issue can run back-to-back
        req_d   = (req_q && !avl_ready) ||
                  (state_d == FETCH && cnt_d < CW'(TOTAL) &&
                   ({1'b0, lvl_nx} + {1'b0, out_d}) < (LW+1)'(FIFO_DEPTH));
        pix_d   = !pix_de ? pix_q : pop ? head : '0;
        und_d   = restart ? 1'b0 : (und_q || (pix_de && empty));
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q   <= 1'b0;
            addr_q  <= BASE_ADDR;
            cnt_q   <= '0;
            out_q   <= '0;
            disc_q  <= '0;
            stale_q <= 1'b0;
            pix_q   <= '0;
            und_q   <= 1'b0;
        end else begin
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            stale_q <= stale_d;
            pix_q   <= pix_d;
            und_q   <= und_d;
        end
    end
    assign avl_read_req = req_q;
    assign avl_addr     = addr_q;
    assign pix_data     = pix_q;
    assign underflow    = und_q;
    assign fifo_level   = level;
endmodule
